// File: rtl/int_sequencer.sv
// int_sequencer
//
// Interrupt entry/exit sequencer placed after the vectored priority interrupt
// system. On an accepted interrupt it acknowledges the pending flag, redirects
// the CPU to the ISR vector, and on return-from-interrupt redirects back to the
// saved PC. Owns the global interrupt enable (gie). Nesting is not supported.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_clr          asynchronous active-low reset
//   i_int_pending  pending flag from interrupt system (already masked)
//   i_isr_addr     ISR vector from interrupt system
//   i_pc           CPU PC of the next instruction to execute
//   i_instr_done   CPU instruction-boundary strobe
//   i_reti_req     CPU decoded return-from-interrupt strobe
//   i_gie_set      software enable-interrupts strobe
//   i_gie_clr      software disable-interrupts strobe (wins over set)
//   o_clr_pend     active-low one-cycle pulse clearing the pending flag
//   o_int_disable  masks the interrupt system's pending flag
//   o_stall        CPU must not fetch or retire while high
//   o_pc_load      CPU loads o_pc_out into its PC this cycle
//   o_pc_out       redirect target, zero when o_pc_load is low
//   o_in_isr       high while executing an ISR
//
// All outputs are registered; each output register holds the value that
// belongs to the state being entered, so outputs line up with the state
// register and there is no input-to-output combinational path.

module int_sequencer #(
    parameter int unsigned PcWidth = 16
) (
    input  logic               i_clk,
    input  logic               i_clr,
    input  logic               i_int_pending,
    input  logic [PcWidth-1:0] i_isr_addr,
    input  logic [PcWidth-1:0] i_pc,
    input  logic               i_instr_done,
    input  logic               i_reti_req,
    input  logic               i_gie_set,
    input  logic               i_gie_clr,
    output logic               o_clr_pend,
    output logic               o_int_disable,
    output logic               o_stall,
    output logic               o_pc_load,
    output logic [PcWidth-1:0] o_pc_out,
    output logic               o_in_isr
);

    typedef enum logic [2:0] {
        StIdle,
        StAck,
        StVector,
        StIsr,
        StReturn
    } state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic               r_gie;
    logic               w_gie_d;
    logic [PcWidth-1:0] r_saved_pc;
    logic [PcWidth-1:0] w_saved_pc_d;
    logic [PcWidth-1:0] r_vec;
    logic [PcWidth-1:0] w_vec_d;

    logic               r_clr_pend;
    logic               r_int_disable;
    logic               r_stall;
    logic               r_pc_load;
    logic [PcWidth-1:0] r_pc_out;
    logic               r_in_isr;

    logic               w_clr_pend_d;
    logic               w_int_disable_d;
    logic               w_stall_d;
    logic               w_pc_load_d;
    logic [PcWidth-1:0] w_pc_out_d;
    logic               w_in_isr_d;
    logic               w_accept;

    // Acceptance uses the current gie, so a coincident gieSet cannot enable
    // acceptance in the same cycle, while a coincident gieClr blocks it.
    assign w_accept = i_int_pending & i_instr_done & r_gie & ~i_gie_clr;

    always_comb begin
        w_state_d    = r_state;
        w_saved_pc_d = r_saved_pc;
        w_vec_d      = r_vec;

        if (i_gie_clr) begin
            w_gie_d = 1'b0;
        end else if (i_gie_set) begin
            w_gie_d = 1'b1;
        end else begin
            w_gie_d = r_gie;
        end

        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_d = StAck;
                end
            end
            StAck: begin
                w_saved_pc_d = i_pc;
                w_vec_d      = i_isr_addr;
                w_state_d    = StVector;
            end
            StVector: begin
                w_state_d = StIsr;
            end
            StIsr: begin
                if (i_reti_req) begin
                    w_state_d = StReturn;
                end
            end
            StReturn: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Output values for the state about to be entered.
    always_comb begin
        w_clr_pend_d    = (w_state_d != StAck);
        w_int_disable_d = (w_state_d == StIdle) ? ~w_gie_d : 1'b1;
        w_stall_d       = (w_state_d == StAck) || (w_state_d == StVector) ||
                          (w_state_d == StReturn);
        w_pc_load_d     = (w_state_d == StVector) || (w_state_d == StReturn);
        w_in_isr_d      = (w_state_d == StIsr);
        if (w_state_d == StVector) begin
            w_pc_out_d = w_vec_d;
        end else if (w_state_d == StReturn) begin
            w_pc_out_d = w_saved_pc_d;
        end else begin
            w_pc_out_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_clr) begin
        if (!i_clr) begin
            r_state       <= StIdle;
            r_gie         <= 1'b0;
            r_saved_pc    <= '0;
            r_vec         <= '0;
            r_clr_pend    <= 1'b1;
            r_int_disable <= 1'b1;
            r_stall       <= 1'b0;
            r_pc_load     <= 1'b0;
            r_pc_out      <= '0;
            r_in_isr      <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_gie         <= w_gie_d;
            r_saved_pc    <= w_saved_pc_d;
            r_vec         <= w_vec_d;
            r_clr_pend    <= w_clr_pend_d;
            r_int_disable <= w_int_disable_d;
            r_stall       <= w_stall_d;
            r_pc_load     <= w_pc_load_d;
            r_pc_out      <= w_pc_out_d;
            r_in_isr      <= w_in_isr_d;
        end
    end

    assign o_clr_pend    = r_clr_pend;
    assign o_int_disable = r_int_disable;
    assign o_stall       = r_stall;
    assign o_pc_load     = r_pc_load;
    assign o_pc_out      = r_pc_out;
    assign o_in_isr      = r_in_isr;

endmodule
